uart_regs: RTL
==============

# uart_regs

- Register and FIFO front-end of the UART; the processor-interface stage behind the `pi_*` host bus.
- Decodes byte-wide register reads and writes, buffers transmit and receive bytes in two FIFOs, and holds the baud divisor.
- Drives a level interrupt with an explicit acknowledge.
- Downstream it hands bytes to the UART transmitter core and accepts bytes and frame errors from the receiver core.

## Interface
Parameters:
- `DEPTH`, 16: entries per FIFO; power of two, minimum 2.
- `BAUD_RST`, 16'd27: reset value of the baud divisor.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-low reset.
- `pi_blk_sel` in 1: block select; qualifies all bus activity.
- `pi_wr_en` in 1: write strobe, sampled each edge.
- `pi_rd_en` in 1: read strobe, sampled each edge.
- `pi_addr` in 4: register address.
- `pi_wr_data` in 8: write data.
- `pi_rd_data` out 8: read data, registered.
- `interrupt` out 1: level interrupt, registered.
- `interrupt_ack` in 1: one-cycle acknowledge pulse.
- `tx_data` out 8: byte to transmitter core.
- `tx_valid` out 1: `tx_data` valid.
- `tx_ready` in 1: core accepts the byte when `tx_valid & tx_ready`.
- `rx_data` in 8: byte from receiver core.
- `rx_valid` in 1: one-cycle pulse; push `rx_data`.
- `rx_frame_err` in 1: one-cycle pulse; framing error seen.
- `baud_div` out 16: divisor to both cores.

## Operation
Register map; unmapped addresses read 0 and ignore writes.
- 0x0 DATA
  - Write: pushes the TX FIFO.
  - Read: returns the RX FIFO head and pops it.
- 0x1 STATUS
  - Bits: b0 tx_full, b1 tx_empty, b2 rx_empty, b3 rx_full, b4 rx_overrun, b5 frame_err, b6 tx_overflow.
  - b4–b6 are sticky and write-1-to-clear.
- 0x2 IER: b0 rx_avail enable, b1 tx_empty enable, b2 error enable. b7 is LOOP; see Configuration.
- 0x3 BAUD_LO, 0x4 BAUD_HI: read/write.
- 0x5 ISR, read-only: b0 rx_avail (RX not empty), b1 tx_empty_evt, b2 err (b4|b5|b6 of STATUS).

Bus access:
- A write or read access occurs at every edge where `pi_blk_sel` and the strobe are high. A strobe held N cycles counts as N accesses.
- Write to DATA with the TX FIFO full: byte dropped, tx_overflow set.
- `rx_valid` with the RX FIFO full and no pop in the same cycle: byte dropped, rx_overrun set.
- Simultaneous push and pop on a full FIFO: both proceed, no overrun.
- Reading DATA with the RX FIFO empty returns 0x00 and does not move the pointers.
- `rx_frame_err` sets frame_err; the accompanying `rx_valid` byte is still pushed.

TX path:
- `tx_valid` = TX FIFO not empty.
- `tx_data` = TX FIFO head; FWFT, so the byte is presented without a read cycle.
- Pop on `tx_valid & tx_ready`.

Interrupts:
- tx_empty_evt is set on the cycle the TX FIFO goes from non-empty to empty.
- tx_empty_evt is cleared by `interrupt_ack` or by any DATA write; set wins over clear in the same cycle.
- `interrupt` is registered `|(ISR[2:0] & IER[2:0])`.
- rx_avail clears only by draining the RX FIFO; err clears only by W1C.

Reset (`rst` low at an edge):
- Both FIFOs empty, all sticky bits 0, IER 0, `baud_div` = BAUD_RST.
- `pi_rd_data` 0, `interrupt` 0, `tx_valid` 0, `tx_data` 0.
- Reset mid-access discards the access.

## Timing
- `pi_rd_data`:
  - Loaded every edge with `pi_blk_sel` high from the mux at `pi_addr`; with `pi_blk_sel` low it is 0.
  - So an address presented one cycle before `pi_rd_en` is valid throughout the strobe cycle.
- RX pop takes effect at the edge that samples `pi_rd_en`; the next DATA read sees the next byte.
- Write latency: register or FIFO updated at the sampling edge. `tx_valid` rises 1 cycle after a write to an empty TX FIFO.
- `interrupt`: 1 cycle after the cause and enable are both true. It drops 1 cycle after the cause clears or on the edge after `interrupt_ack`.
- FIFO pointers are log2(DEPTH)+1 bits; full/empty come from MSB compare and wrap naturally.
- Status flags reflect the post-edge state.

## Configuration
- `UART_REGS_LOOPBACK_EN` defined:
  - IER b7 (LOOP) is read/write.
  - When LOOP=1, a TX FIFO pop is pushed into the RX FIFO the same cycle; pops occur every cycle while the TX FIFO is not empty, ignoring `tx_ready`.
  - When LOOP=1, `tx_valid` is forced 0 and `rx_valid` is ignored.
- Undefined: IER b7 reads 0, writes to it are ignored, no loopback logic is built.

## Test plan
- Reset: drive `rst`=0 for 2 edges.
  - -> `interrupt`=0, `tx_valid`=0, BAUD read returns 0x1B/0x00, STATUS reads 0x06.
- Write 0x3C to BAUD_LO and 0x01 to BAUD_HI -> `baud_div`=0x013C; read back matches.
- Write 0xA5 to DATA with `tx_ready`=0 -> `tx_valid`=1, `tx_data`=0xA5.
  - Raise `tx_ready` 1 cycle -> `tx_valid`=0.
  - With IER=0x02, tx_empty_evt sets and `interrupt`=1; `interrupt_ack` pulse -> `interrupt`=0.
- Fill TX FIFO with 17 writes, `tx_ready`=0 -> STATUS=0x41.
  - Write 0x40 to STATUS -> b6 cleared.
  - First popped byte is the first written.
- Pulse `rx_valid` 17 times (0x00..0x10) with IER=0x05 -> `interrupt`=1, STATUS b3 and b4 set.
  - 16 DATA reads return 0x00..0x0F; the 17th returns 0x00, rx_empty=1.
- With `UART_REGS_LOOPBACK_EN` and IER=0x80, write 0x5A to DATA -> `tx_valid` stays 0; DATA read returns 0x5A.

Source files
------------

// File: rtl/uart_regs.sv
// uart_regs: host register file and TX/RX byte FIFOs for the UART.
// Optional build macro UART_REGS_LOOPBACK_EN adds the IER.LOOP bit, which turns TX pops into RX
// pushes. Without the macro, no loopback logic is built.
module uart_regs #(
  parameter int unsigned DEPTH    = 16,
  parameter logic [15:0] BAUD_RST = 16'd27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pi_blk_sel,
  input  logic        pi_wr_en,
  input  logic        pi_rd_en,
  input  logic [3:0]  pi_addr,
  input  logic [7:0]  pi_wr_data,
  output logic [7:0]  pi_rd_data,
  output logic        interrupt,
  input  logic        interrupt_ack,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_frame_err,
  output logic [15:0] baud_div
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [3:0] AddrData   = 4'h0;
  localparam logic [3:0] AddrStatus = 4'h1;
  localparam logic [3:0] AddrIer    = 4'h2;
  localparam logic [3:0] AddrBaudLo = 4'h3;
  localparam logic [3:0] AddrBaudHi = 4'h4;
  localparam logic [3:0] AddrIsr    = 4'h5;

  logic wr_acc, rd_acc;
  assign wr_acc = pi_blk_sel & pi_wr_en;
  assign rd_acc = pi_blk_sel & pi_rd_en;

  // Register state
  logic [2:0]  ier_q, ier_d;
  logic [7:0]  baud_lo_q, baud_lo_d, baud_hi_q, baud_hi_d;
  logic        rx_ovr_q, rx_ovr_d, frame_q, frame_d, tx_ovf_q, tx_ovf_d;
  logic        tx_evt_q, tx_evt_d;
  logic        irq_q, irq_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        loop_en;

`ifdef UART_REGS_LOOPBACK_EN
  logic loop_q, loop_d;
  assign loop_en = loop_q;
`else
  assign loop_en = 1'b0;
`endif

  // TX FIFO (first-word fall-through); extra pointer MSB separates full from empty
  logic [7:0]  tx_mem [DEPTH];
  logic [AW:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic        tx_empty, tx_full, tx_empty_next;
  logic        tx_push_req, tx_push, tx_pop;
  logic [7:0]  tx_head;

  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign tx_full  = (tx_wptr_q[AW] != tx_rptr_q[AW]) &&
                    (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);
  assign tx_head  = tx_mem[tx_rptr_q[AW-1:0]];

  // In loopback the FIFO drains every cycle regardless of the core handshake
  assign tx_pop      = !tx_empty && (loop_en || tx_ready);
  assign tx_push_req = wr_acc && (pi_addr == AddrData);
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);
  assign tx_wptr_d   = tx_wptr_q + {{AW{1'b0}}, tx_push};
  assign tx_rptr_d   = tx_rptr_q + {{AW{1'b0}}, tx_pop};
  assign tx_empty_next = (tx_wptr_d == tx_rptr_d);

  assign tx_valid = !tx_empty && !loop_en;
  assign tx_data  = tx_empty ? 8'h00 : tx_head;

  // RX FIFO
  logic [7:0]  rx_mem [DEPTH];
  logic [AW:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic        rx_empty, rx_full;
  logic        rx_push_req, rx_push, rx_pop;
  logic [7:0]  rx_push_data, rx_head;

  assign rx_empty = (rx_wptr_q == rx_rptr_q);
  assign rx_full  = (rx_wptr_q[AW] != rx_rptr_q[AW]) &&
                    (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);
  assign rx_head  = rx_mem[rx_rptr_q[AW-1:0]];

  assign rx_push_req  = loop_en ? tx_pop : rx_valid;
  assign rx_push_data = loop_en ? tx_head : rx_data;
  assign rx_pop       = rd_acc && (pi_addr == AddrData) && !rx_empty;
  assign rx_push      = rx_push_req && (!rx_full || rx_pop);
  assign rx_wptr_d    = rx_wptr_q + {{AW{1'b0}}, rx_push};
  assign rx_rptr_d    = rx_rptr_q + {{AW{1'b0}}, rx_pop};

  // Status and interrupt cause vectors from current state
  logic [7:0] status_val, isr_val, ier_val;
  logic       err;

  assign err        = rx_ovr_q | frame_q | tx_ovf_q;
  assign status_val = {1'b0, tx_ovf_q, frame_q, rx_ovr_q, rx_full, rx_empty, tx_empty, tx_full};
  assign isr_val    = {5'b0, err, tx_evt_q, !rx_empty};
`ifdef UART_REGS_LOOPBACK_EN
  assign ier_val    = {loop_q, 4'b0, ier_q};
`else
  assign ier_val    = {5'b0, ier_q};
`endif

  // FIFO storage writes; contents need no reset because pointers gate visibility
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q[AW-1:0]] <= pi_wr_data;
    if (rx_push) rx_mem[rx_wptr_q[AW-1:0]] <= rx_push_data;
  end

  // Next-state for registers, sticky flags, interrupt and read-data mux
  always_comb begin
    logic sts_wr;
    ier_d     = ier_q;
    baud_lo_d = baud_lo_q;
    baud_hi_d = baud_hi_q;
    rx_ovr_d  = rx_ovr_q;
    frame_d   = frame_q;
    tx_ovf_d  = tx_ovf_q;
    tx_evt_d  = tx_evt_q;
    rd_data_d = 8'h00;
`ifdef UART_REGS_LOOPBACK_EN
    loop_d    = loop_q;
`endif

    sts_wr = wr_acc && (pi_addr == AddrStatus);

    if (wr_acc && (pi_addr == AddrIer)) begin
      ier_d = pi_wr_data[2:0];
`ifdef UART_REGS_LOOPBACK_EN
      loop_d = pi_wr_data[7];
`endif
    end
    if (wr_acc && (pi_addr == AddrBaudLo)) baud_lo_d = pi_wr_data;
    if (wr_acc && (pi_addr == AddrBaudHi)) baud_hi_d = pi_wr_data;

    // W1C first so a same-cycle event still leaves the flag set
    if (sts_wr && pi_wr_data[4]) rx_ovr_d = 1'b0;
    if (sts_wr && pi_wr_data[5]) frame_d  = 1'b0;
    if (sts_wr && pi_wr_data[6]) tx_ovf_d = 1'b0;
    if (rx_push_req && rx_full && !rx_pop) rx_ovr_d = 1'b1;
    if (rx_frame_err) frame_d = 1'b1;
    if (tx_push_req && tx_full && !tx_pop) tx_ovf_d = 1'b1;

    if (interrupt_ack || tx_push_req) tx_evt_d = 1'b0;
    if (!tx_empty && tx_empty_next)   tx_evt_d = 1'b1;

    irq_d = |(isr_val[2:0] & ier_q);

    if (pi_blk_sel) begin
      case (pi_addr)
        AddrData:   rd_data_d = rx_empty ? 8'h00 : rx_head;
        AddrStatus: rd_data_d = status_val;
        AddrIer:    rd_data_d = ier_val;
        AddrBaudLo: rd_data_d = baud_lo_q;
        AddrBaudHi: rd_data_d = baud_hi_q;
        AddrIsr:    rd_data_d = isr_val;
        default:    rd_data_d = 8'h00;
      endcase
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      ier_q     <= '0;
      baud_lo_q <= BAUD_RST[7:0];
      baud_hi_q <= BAUD_RST[15:8];
      rx_ovr_q  <= 1'b0;
      frame_q   <= 1'b0;
      tx_ovf_q  <= 1'b0;
      tx_evt_q  <= 1'b0;
      irq_q     <= 1'b0;
      rd_data_q <= 8'h00;
`ifdef UART_REGS_LOOPBACK_EN
      loop_q    <= 1'b0;
`endif
    end else begin
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      ier_q     <= ier_d;
      baud_lo_q <= baud_lo_d;
      baud_hi_q <= baud_hi_d;
      rx_ovr_q  <= rx_ovr_d;
      frame_q   <= frame_d;
      tx_ovf_q  <= tx_ovf_d;
      tx_evt_q  <= tx_evt_d;
      irq_q     <= irq_d;
      rd_data_q <= rd_data_d;
`ifdef UART_REGS_LOOPBACK_EN
      loop_q    <= loop_d;
`endif
    end
  end

  assign pi_rd_data = rd_data_q;
  assign interrupt  = irq_q;
  assign baud_div   = {baud_hi_q, baud_lo_q};

endmodule
